// File: rtl/uart_cmd_pkg.sv
// Shared opcode/response constants, FSM encoding and opcode decoder for the
// UART command parser and its helpers.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_UNK = 8'h3F;

    localparam int TIMEOUT_DEFAULT = 120000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_A   = 3'd1,
        ST_GET_D   = 3'd2,
        ST_BUS_WR  = 3'd3,
        ST_BUS_RD  = 3'd4,
        ST_RD_CAP  = 3'd5,
        ST_TX_WAIT = 3'd6,
        ST_TX_HOLD = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CMD_WR  = 2'd0,
        CMD_RD  = 2'd1,
        CMD_BAD = 2'd2
    } cmd_t;

    function automatic cmd_t decode_op(input logic [7:0] op);
        cmd_t cmd;
        case (op)
            OP_WR:   cmd = CMD_WR;
            OP_RD:   cmd = CMD_RD;
            default: cmd = CMD_BAD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte watchdog for byte-oriented protocol engines: reloads on clr,
// counts down while en, and flags expire on the last counted cycle.
module uart_frame_timer #(
    parameter int CYC = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW   = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CYC - 1);

    logic [CW-1:0] cnt_r;

    // Reload on clear; otherwise count down while enabled and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= LOAD;
        end else if (clr) begin
            cnt_r <= LOAD;
        end else if (en && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A clear in the same cycle always wins over expiry.
    assign expire = en && !clr && (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: decodes 'W' addr data / 'R' addr frames from the rxtx
// core, performs one register access and returns a single response byte.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT,
    parameter int AW          = 8,
    parameter int DW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_vld,
    input  logic [7:0]    rx_data,
    input  logic          txrdy,
    output logic          tx_vld,
    output logic [7:0]    tx_data,
    output logic          reg_wr,
    output logic          reg_rd,
    output logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_wdata,
    input  logic [DW-1:0] reg_rdata,
    output logic          busy,
    output logic          err_ovr
);

    state_t        state_r;
    state_t        state_s;
    logic          is_wr_r;
    logic [AW-1:0] reg_addr_r;
    logic [DW-1:0] reg_wdata_r;
    logic [7:0]    rsp_r;
    logic [7:0]    rsp_s;
    logic [7:0]    tx_data_r;
    logic          tx_vld_r;
    logic          reg_wr_r;
    logic          reg_rd_r;
    logic          busy_r;
    logic          err_ovr_r;

    logic          accept_s;
    logic          op_ld_s;
    logic          addr_ld_s;
    logic          data_ld_s;
    logic          rsp_ld_s;
    logic          tx_fire_s;
    logic          ovr_s;
    logic          in_frame_s;
    logic          tmr_clr_s;
    logic          tmr_exp_s;

    assign in_frame_s = (state_r == ST_GET_A) || (state_r == ST_GET_D);
    assign tmr_clr_s  = accept_s || !in_frame_s;
    assign ovr_s      = rx_vld && !((state_r == ST_IDLE) || in_frame_s);

    uart_frame_timer #(
        .CYC (TIMEOUT_CYC)
    ) u_frame_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr_s),
        .en     (in_frame_s),
        .expire (tmr_exp_s)
    );

    // Next-state decode plus the one-cycle load/fire strobes for the datapath.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        op_ld_s   = 1'b0;
        addr_ld_s = 1'b0;
        data_ld_s = 1'b0;
        rsp_ld_s  = 1'b0;
        rsp_s     = rsp_r;
        tx_fire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_vld) begin
                    accept_s = 1'b1;
                    op_ld_s  = 1'b1;
                    case (decode_op(rx_data))
                        CMD_WR:  state_s = ST_GET_A;
                        CMD_RD:  state_s = ST_GET_A;
                        default: begin
                            state_s  = ST_TX_WAIT;
                            rsp_ld_s = 1'b1;
                            rsp_s    = RSP_UNK;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GET_A: begin
                if (rx_vld) begin
                    accept_s  = 1'b1;
                    addr_ld_s = 1'b1;
                    state_s   = is_wr_r ? ST_GET_D : ST_BUS_RD;
                end else if (tmr_exp_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GET_A;
                end
            end
            ST_GET_D: begin
                if (rx_vld) begin
                    accept_s  = 1'b1;
                    data_ld_s = 1'b1;
                    state_s   = ST_BUS_WR;
                end else if (tmr_exp_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GET_D;
                end
            end
            ST_BUS_WR: begin
                rsp_ld_s = 1'b1;
                rsp_s    = RSP_ACK;
                state_s  = ST_TX_WAIT;
            end
            ST_BUS_RD: begin
                state_s = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                // reg_rd is a registered pulse, so read data lands the cycle after it drops.
                if (!reg_rd_r) begin
                    rsp_ld_s = 1'b1;
                    rsp_s    = 8'(reg_rdata);
                    state_s  = ST_TX_WAIT;
                end else begin
                    state_s = ST_RD_CAP;
                end
            end
            ST_TX_WAIT: begin
                if (txrdy) begin
                    tx_fire_s = 1'b1;
                    state_s   = ST_TX_HOLD;
                end else begin
                    state_s = ST_TX_WAIT;
                end
            end
            ST_TX_HOLD: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, frame datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            is_wr_r     <= 1'b0;
            reg_addr_r  <= {AW{1'b0}};
            reg_wdata_r <= {DW{1'b0}};
            rsp_r       <= 8'h00;
            tx_data_r   <= 8'h00;
            tx_vld_r    <= 1'b0;
            reg_wr_r    <= 1'b0;
            reg_rd_r    <= 1'b0;
            busy_r      <= 1'b0;
            err_ovr_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            reg_wr_r <= (state_r == ST_BUS_WR);
            reg_rd_r <= (state_r == ST_BUS_RD);
            tx_vld_r <= tx_fire_s;
            busy_r   <= (state_s != ST_IDLE);
            if (ovr_s) begin
                err_ovr_r <= 1'b1;
            end
            if (op_ld_s) begin
                is_wr_r <= (decode_op(rx_data) == CMD_WR);
            end
            if (addr_ld_s) begin
                reg_addr_r <= AW'(rx_data);
            end
            if (data_ld_s) begin
                reg_wdata_r <= DW'(rx_data);
            end
            if (rsp_ld_s) begin
                rsp_r <= rsp_s;
            end
            if (tx_fire_s) begin
                tx_data_r <= rsp_r;
            end
        end
    end

    assign tx_vld    = tx_vld_r;
    assign tx_data   = tx_data_r;
    assign reg_wr    = reg_wr_r;
    assign reg_rd    = reg_rd_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign busy      = busy_r;
    assign err_ovr   = err_ovr_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: direct rx_vld byte pulses, a 256x8
// register RAM, and a reference memory predicting every response byte.
module tb_uart_cmd_parser;

    localparam int TO = 64;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       rx_vld    = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       txrdy     = 1'b1;
    logic [7:0] reg_rdata = 8'h00;
    logic       tx_vld;
    logic [7:0] tx_data;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       busy;
    logic       err_ovr;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ram     [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  tx_q [$];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    bit          idle_to;

    uart_cmd_parser #(
        .TIMEOUT_CYC (TO),
        .AW          (8),
        .DW          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_vld    (rx_vld),
        .rx_data   (rx_data),
        .txrdy     (txrdy),
        .tx_vld    (tx_vld),
        .tx_data   (tx_data),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err_ovr   (err_ovr)
    );

    always #5 clk = ~clk;

    // Register RAM; read data is only meaningful the cycle after reg_rd.
    always @(posedge clk) begin
        if (reg_wr) ram[reg_addr] <= reg_wdata;
        reg_rdata <= reg_rd ? ram[reg_addr] : 8'($urandom);
    end

    // Record every response byte and bus access.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_vld) tx_q.push_back(tx_data);
            if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
            if (reg_rd) rd_q.push_back(reg_addr);
        end
    end

    function automatic logic [7:0] head8(input logic [7:0] q [$]);
        return (q.size() > 0) ? q[0] : 8'hEE;
    endfunction

    task automatic clear_mon();
        tx_q.delete();
        wr_q.delete();
        rd_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_vld  = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_vld  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        idle_to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_to = 1'b0;
                break;
            end
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int n, input int gap);
        clear_mon();
        send_byte(b0);
        if (n > 1) begin
            repeat (gap) @(posedge clk);
            send_byte(b1);
        end
        if (n > 2) begin
            repeat (gap) @(posedge clk);
            send_byte(b2);
        end
        wait_idle(80);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_vld = 1'b0; txrdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({tx_vld, reg_wr, reg_rd, busy, err_ovr} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 00000", {tx_vld, reg_wr, reg_rd, busy, err_ovr}); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if ({reg_addr, reg_wdata} !== 16'h0000) begin errors++; $display("FAIL reset_addr_data: got %h expected 0000", {reg_addr, reg_wdata}); end
    endtask

    task automatic test_write();
        clear_mon();
        send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
        @(negedge clk);
        checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL wr_early: got %b expected 0", reg_wr); end
        @(negedge clk);
        checks++; if ({reg_wr, reg_addr, reg_wdata} !== {1'b1, 8'h10, 8'hA5}) begin errors++; $display("FAIL wr_pulse: got %b/%h/%h expected 1/10/a5", reg_wr, reg_addr, reg_wdata); end
        @(negedge clk);
        checks++; if ({tx_vld, tx_data} !== {1'b1, 8'h4B}) begin errors++; $display("FAIL wr_ack_latency: got %b/%h expected 1/4b", tx_vld, tx_data); end
        ref_mem[8'h10] = 8'hA5;
        wait_idle(40);
        checks++; if (idle_to) begin errors++; $display("FAIL wr_idle_timeout: got busy expected idle"); end
        checks++; if (wr_q.size() != 1 || tx_q.size() != 1) begin errors++; $display("FAIL wr_counts: got wr=%0d tx=%0d expected 1/1", wr_q.size(), tx_q.size()); end
        checks++; if (tx_data !== 8'h4B) begin errors++; $display("FAIL tx_data_hold: got %h expected 4b", tx_data); end
    endtask

    task automatic test_read();
        clear_mon();
        send_byte(8'h52); send_byte(8'h10);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({reg_rd, reg_addr} !== {1'b1, 8'h10}) begin errors++; $display("FAIL rd_pulse: got %b/%h expected 1/10", reg_rd, reg_addr); end
        wait_idle(40);
        checks++; if (tx_q.size() != 1 || head8(tx_q) !== ref_mem[8'h10]) begin errors++; $display("FAIL rd_resp: got n=%0d %h expected 1 %h", tx_q.size(), head8(tx_q), ref_mem[8'h10]); end
        checks++; if (rd_q.size() != 1 || wr_q.size() != 0) begin errors++; $display("FAIL rd_counts: got rd=%0d wr=%0d expected 1/0", rd_q.size(), wr_q.size()); end
        checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL rd_err_ovr: got %b expected 0", err_ovr); end
    endtask

    task automatic test_unknown();
        send_frame(8'h33, 8'h00, 8'h00, 1, 0);
        checks++; if (tx_q.size() != 1 || head8(tx_q) !== 8'h3F) begin errors++; $display("FAIL unk_resp: got n=%0d %h expected 1 3f", tx_q.size(), head8(tx_q)); end
        checks++; if (rd_q.size() + wr_q.size() != 0) begin errors++; $display("FAIL unk_bus: got %0d accesses expected 0", rd_q.size() + wr_q.size()); end
        send_frame(8'h52, 8'h00, 8'h00, 2, 0);
        checks++; if (tx_q.size() != 1 || head8(tx_q) !== ref_mem[8'h00]) begin errors++; $display("FAIL unk_next_rd: got n=%0d %h expected 1 %h", tx_q.size(), head8(tx_q), ref_mem[8'h00]); end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_byte(8'h57); send_byte(8'h20);
        repeat (TO + 10) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
        checks++; if (wr_q.size() + tx_q.size() + rd_q.size() != 0) begin errors++; $display("FAIL to_silent: got %0d events expected 0", wr_q.size() + tx_q.size() + rd_q.size()); end
        send_frame(8'h52, 8'h20, 8'h00, 2, 1);
        checks++; if (tx_q.size() != 1 || head8(tx_q) !== ref_mem[8'h20]) begin errors++; $display("FAIL to_next_rd: got n=%0d %h expected 1 %h", tx_q.size(), head8(tx_q), ref_mem[8'h20]); end
        // Bytes landing exactly on the expiry cycle are still accepted.
        send_frame(8'h57, 8'h21, 8'h5C, 3, TO - 2);
        checks++; if (wr_q.size() != 1 || wr_q[0] !== 16'h215C) begin errors++; $display("FAIL to_edge_wr: got n=%0d expected 1 write 215c", wr_q.size()); end
        ref_mem[8'h21] = 8'h5C;
        // One cycle later the frame is gone and the byte is decoded as an opcode.
        send_frame(8'h57, 8'h22, 8'h00, 2, TO - 1);
        checks++; if (tx_q.size() != 1 || head8(tx_q) !== 8'h3F || wr_q.size() != 0) begin errors++; $display("FAIL to_late_byte: got n=%0d %h wr=%0d expected 1 3f 0", tx_q.size(), head8(tx_q), wr_q.size()); end
        checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL to_err_ovr: got %b expected 0", err_ovr); end
    endtask

    task automatic test_overrun();
        clear_mon();
        txrdy = 1'b0;
        send_byte(8'h52); send_byte(8'h10);
        repeat (10) @(posedge clk);
        #2;
        checks++; if (tx_q.size() != 0 || busy !== 1'b1) begin errors++; $display("FAIL ovr_holdoff: got n=%0d busy=%b expected 0 1", tx_q.size(), busy); end
        send_byte(8'h11);
        @(negedge clk);
        checks++; if (err_ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", err_ovr); end
        @(posedge clk); #1 txrdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({tx_vld, tx_data, busy} !== {1'b1, ref_mem[8'h10], 1'b1}) begin errors++; $display("FAIL ovr_tx: got %b/%h/%b expected 1/%h/1", tx_vld, tx_data, busy, ref_mem[8'h10]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_busy_fall: got %b expected 0", busy); end
        repeat (5) @(posedge clk);
        #2;
        checks++; if (tx_q.size() != 1 || wr_q.size() != 0 || rd_q.size() != 1) begin errors++; $display("FAIL ovr_counts: got tx=%0d wr=%0d rd=%0d expected 1/0/1", tx_q.size(), wr_q.size(), rd_q.size()); end
        checks++; if (err_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", err_ovr); end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        send_byte(8'h57); send_byte(8'h30);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({tx_vld, reg_wr, reg_rd, busy, err_ovr} !== 5'b0) begin errors++; $display("FAIL rst_mid_strobes: got %b expected 00000", {tx_vld, reg_wr, reg_rd, busy, err_ovr}); end
        checks++; if ({tx_data, reg_addr, reg_wdata} !== 24'h0) begin errors++; $display("FAIL rst_mid_regs: got %h expected 000000", {tx_data, reg_addr, reg_wdata}); end
        repeat (10) @(posedge clk);
        #2;
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL rst_mid_nowrite: got %0d writes expected 0", wr_q.size()); end
        send_frame(8'h57, 8'h31, 8'h7E, 3, 0);
        checks++; if (tx_q.size() != 1 || head8(tx_q) !== 8'h4B || wr_q.size() != 1) begin errors++; $display("FAIL rst_mid_next_wr: got n=%0d %h wr=%0d expected 1 4b 1", tx_q.size(), head8(tx_q), wr_q.size()); end
        ref_mem[8'h31] = 8'h7E;
        send_frame(8'h52, 8'h30, 8'h00, 2, 0);
        checks++; if (head8(tx_q) !== ref_mem[8'h30]) begin errors++; $display("FAIL rst_mid_rd30: got %h expected %h", head8(tx_q), ref_mem[8'h30]); end
    endtask

    task automatic test_random();
        int         kind;
        int         gap;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] op;
        logic [7:0] exp;
        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 2));
            gap  = int'($urandom_range(0, 3));
            a    = 8'($urandom_range(0, 15));
            d    = 8'($urandom);
            if (kind == 0) begin
                send_frame(8'h57, a, d, 3, gap);
                exp = 8'h4B;
                checks++; if (wr_q.size() != 1 || wr_q[0] !== {a, d}) begin errors++; $display("FAIL rnd_wr[%0d]: got n=%0d expected write %h%h", k, wr_q.size(), a, d); end
                ref_mem[a] = d;
            end else if (kind == 1) begin
                send_frame(8'h52, a, 8'h00, 2, gap);
                exp = ref_mem[a];
                checks++; if (rd_q.size() != 1 || head8(rd_q) !== a) begin errors++; $display("FAIL rnd_rd_addr[%0d]: got n=%0d %h expected 1 %h", k, rd_q.size(), head8(rd_q), a); end
            end else begin
                op = 8'($urandom);
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
                send_frame(op, 8'h00, 8'h00, 1, gap);
                exp = 8'h3F;
                checks++; if (wr_q.size() + rd_q.size() != 0) begin errors++; $display("FAIL rnd_unk_bus[%0d]: got %0d accesses expected 0", k, wr_q.size() + rd_q.size()); end
            end
            checks++; if (idle_to || tx_q.size() != 1 || head8(tx_q) !== exp) begin errors++; $display("FAIL rnd_resp[%0d]: got to=%0d n=%0d %h expected 1 %h", k, idle_to, tx_q.size(), head8(tx_q), exp); end
        end
        checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL rnd_err_ovr: got %b expected 0", err_ovr); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        test_reset();
        test_write();
        test_read();
        test_unknown();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
